// File: rtl/lexington.sv
// Shared types and defaults for the core's peripheral-bus AXI4-Lite master.
package lexington;

  localparam int DEFAULT_AXI_ADDR_WIDTH = 32;
  localparam int DEFAULT_AXI_TIMEOUT    = 255;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } axi_resp_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    WRESP = 3'd2,
    READ  = 3'd3,
    RDATA = 3'd4,
    DONE  = 3'd5
  } axi_master_state_t;

  // States where the master is waiting on the slave and the timeout runs.
  function automatic logic is_wait_state(axi_master_state_t s);
    return (s == WRITE) || (s == WRESP) || (s == READ) || (s == RDATA);
  endfunction

  // SLVERR and DECERR fault the access; EXOKAY is treated as a normal OK.
  function automatic logic resp_is_error(logic [1:0] resp);
    axi_resp_t r;
    r = axi_resp_t'(resp);
    return (r == SLVERR) || (r == DECERR);
  endfunction

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: turns the core's simple read/write
// strobes into AW/W/B or AR/R sequences, stalling the core via axi_busy.
// Error responses and unresponsive slaves both surface as axi_access_fault
// during the one-cycle DONE state.
module axi_lite_master
  import lexington::*;
#(
  parameter int ADDR_WIDTH     = DEFAULT_AXI_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_AXI_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  axi_rd_en,
  input  logic                  axi_wr_en,
  input  logic [ADDR_WIDTH-1:0] axi_addr,
  input  logic [31:0]           wr_data,
  input  logic [3:0]            wr_strobe,
  output logic [31:0]           axi_rd_data,
  output logic                  axi_access_fault,
  output logic                  axi_busy,
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic [2:0]            m_awprot,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [31:0]           m_wdata,
  output logic [3:0]            m_wstrb,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [2:0]            m_arprot,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [31:0]           m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rvalid,
  output logic                  m_rready
);

  localparam int              CW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   TO_MAX = CW'(TIMEOUT_CYCLES);

  axi_master_state_t     state, state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic                  aw_done, w_done;
  logic [CW-1:0]         cnt;
  logic                  timeout;
  logic                  fault_q, fault_next;
  logic [31:0]           rd_data_q;
  logic                  rd_load;

  assign m_awaddr         = addr_q;
  assign m_araddr         = addr_q;
  assign m_wdata          = wdata_q;
  assign m_wstrb          = wstrb_q;
  assign m_awprot         = 3'b000;
  assign m_arprot         = 3'b000;
  assign axi_rd_data      = rd_data_q;
  assign axi_access_fault = fault_q;
  assign timeout          = (cnt == TO_MAX);

  // Next state, channel valids/readies, stall and completion fault.
  always_comb begin
    state_next = state;
    axi_busy   = 1'b0;
    m_awvalid  = 1'b0;
    m_wvalid   = 1'b0;
    m_bready   = 1'b0;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    fault_next = 1'b0;
    rd_load    = 1'b0;
    case (state)
      IDLE: begin
        axi_busy = axi_rd_en | axi_wr_en;
        if (axi_wr_en)      state_next = WRITE;
        else if (axi_rd_en) state_next = READ;
      end
      WRITE: begin
        axi_busy = 1'b1;
        if (timeout) begin
          state_next = DONE;
          fault_next = 1'b1;
        end else begin
          m_awvalid = ~aw_done;
          m_wvalid  = ~w_done;
          if ((aw_done | m_awready) && (w_done | m_wready)) state_next = WRESP;
        end
      end
      WRESP: begin
        axi_busy = 1'b1;
        if (timeout) begin
          state_next = DONE;
          fault_next = 1'b1;
        end else begin
          m_bready = 1'b1;
          if (m_bvalid) begin
            state_next = DONE;
            fault_next = resp_is_error(m_bresp);
          end
        end
      end
      READ: begin
        axi_busy = 1'b1;
        if (timeout) begin
          state_next = DONE;
          fault_next = 1'b1;
        end else begin
          m_arvalid = 1'b1;
          if (m_arready) state_next = RDATA;
        end
      end
      RDATA: begin
        axi_busy = 1'b1;
        if (timeout) begin
          state_next = DONE;
          fault_next = 1'b1;
        end else begin
          m_rready = 1'b1;
          if (m_rvalid) begin
            state_next = DONE;
            fault_next = resp_is_error(m_rresp);
            rd_load    = 1'b1;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Timeout counter: restarts on every state change, runs while waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        cnt <= '0;
    else if (state_next != state)   cnt <= '0;
    else if (is_wait_state(state))  cnt <= cnt + 1'b1;
  end

  // Capture the request so the bus sees stable values for the whole transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (state == IDLE) begin
      if (axi_wr_en) begin
        addr_q  <= axi_addr;
        wdata_q <= wr_data;
        wstrb_q <= wr_strobe;
      end else if (axi_rd_en) begin
        addr_q  <= axi_addr;
      end
    end
  end

  // Per-channel handshake flags so AW and W can complete independently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (state != WRITE) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (m_awvalid && m_awready) aw_done <= 1'b1;
      if (m_wvalid && m_wready)   w_done  <= 1'b1;
    end
  end

  // Fault is only ever visible in DONE; read data holds until the next read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      fault_q <= (state_next == DONE) ? fault_next : 1'b0;
      if (rd_load) rd_data_q <= m_rdata;
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed plus randomized bench for axi_lite_master with an in-bench slave
// and a latency/response model derived from the transaction rules.
module tb_axi_lite_master;

  localparam int AW = 32;
  localparam int T  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          axi_rd_en, axi_wr_en;
  logic [AW-1:0] axi_addr;
  logic [31:0]   wr_data;
  logic [3:0]    wr_strobe;
  logic [31:0]   axi_rd_data;
  logic          axi_access_fault, axi_busy;
  logic [AW-1:0] m_awaddr, m_araddr;
  logic [2:0]    m_awprot, m_arprot;
  logic          m_awvalid, m_awready, m_wvalid, m_wready;
  logic [31:0]   m_wdata, m_rdata;
  logic [3:0]    m_wstrb;
  logic [1:0]    m_bresp, m_rresp;
  logic          m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rd = '0;

  always #5 clk = ~clk;

  axi_lite_master #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .axi_rd_en(axi_rd_en), .axi_wr_en(axi_wr_en), .axi_addr(axi_addr),
    .wr_data(wr_data), .wr_strobe(wr_strobe), .axi_rd_data(axi_rd_data),
    .axi_access_fault(axi_access_fault), .axi_busy(axi_busy),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic slave_idle();
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
    m_arready = 0; m_rvalid = 0; m_rresp = 0; m_rdata = 0;
  endtask

  // One core transaction against a slave with the given per-phase delays
  // (-1 = never responds). Called right after a falling edge.
  task automatic txn(input bit wr, input bit rd, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s,
                     input int aw_d, input int w_d, input int b_d,
                     input int ar_d, input int r_d,
                     input logic [31:0] rdat, input logic [1:0] resp);
    int c, aw_cyc, w_cyc, ar_cyc, b_hs, r_hs, wr_at, ar_at, mx;
    int exp_done, exp_aw, exp_w, exp_ar, exp_b, exp_r;
    bit done, exp_fault;
    logic [31:0] exp_rd_after;
    aw_cyc = 0; w_cyc = 0; ar_cyc = 0; b_hs = 0; r_hs = 0;
    wr_at = -1; ar_at = -1; done = 0;
    exp_rd_after = exp_rd;
    exp_aw = 0; exp_w = 0; exp_ar = 0; exp_b = 0; exp_r = 0;
    // Reference timing: request cycle is 0, each phase adds its wait plus one.
    if (wr) begin
      exp_aw = (aw_d < 0) ? T : aw_d + 1;
      exp_w  = (w_d < 0)  ? T : w_d + 1;
      if (aw_d < 0 || w_d < 0) begin
        exp_done = T + 2; exp_fault = 1;
      end else begin
        mx = (aw_d > w_d) ? aw_d : w_d;
        if (b_d < 0) begin
          exp_done = mx + 2 + T + 1; exp_fault = 1;
        end else begin
          exp_done = mx + 3 + b_d; exp_fault = resp[1]; exp_b = 1;
        end
      end
    end else begin
      exp_ar = (ar_d < 0) ? T : ar_d + 1;
      if (ar_d < 0) begin
        exp_done = T + 2; exp_fault = 1;
      end else if (r_d < 0) begin
        exp_done = ar_d + 2 + T + 1; exp_fault = 1;
      end else begin
        exp_done = ar_d + 3 + r_d; exp_fault = resp[1]; exp_r = 1;
        exp_rd_after = rdat;
      end
    end
    axi_wr_en = wr; axi_rd_en = rd; axi_addr = a; wr_data = d; wr_strobe = s;
    for (c = 0; c < 300 && !done; c++) begin
      #1;
      if (c > 0 && !axi_busy) begin
        chk("done_cycle", c, exp_done);
        chk("done_fault", axi_access_fault, exp_fault);
        exp_rd = exp_rd_after;
        chk("rd_data", axi_rd_data, exp_rd);
        chk("aw_cycles", aw_cyc, exp_aw);
        chk("w_cycles", w_cyc, exp_w);
        chk("ar_cycles", ar_cyc, exp_ar);
        chk("b_hs", b_hs, exp_b);
        chk("r_hs", r_hs, exp_r);
        done = 1;
        axi_wr_en = 0; axi_rd_en = 0;
        slave_idle();
      end else begin
        if (c == 0) chk("busy_req", axi_busy, 1);
        chk("fault_mid", axi_access_fault, 0);
        m_awready = m_awvalid && aw_d >= 0 && aw_cyc >= aw_d;
        m_wready  = m_wvalid && w_d >= 0 && w_cyc >= w_d;
        m_arready = m_arvalid && ar_d >= 0 && ar_cyc >= ar_d;
        if (m_awvalid) begin aw_cyc++; chk("awaddr", m_awaddr, a); end
        if (m_wvalid) begin
          w_cyc++;
          chk("wdata", m_wdata, d);
          chk("wstrb", m_wstrb, s);
        end
        if (m_arvalid) begin ar_cyc++; chk("araddr", m_araddr, a); end
        m_bresp  = resp;
        m_bvalid = wr_at >= 0 && b_d >= 0 && c >= wr_at + 1 + b_d && b_hs == 0;
        m_rresp  = resp;
        m_rdata  = rdat;
        m_rvalid = ar_at >= 0 && r_d >= 0 && c >= ar_at + 1 + r_d && r_hs == 0;
        if (m_bvalid && m_bready) b_hs++;
        if (m_rvalid && m_rready) r_hs++;
        if (m_arvalid && m_arready) ar_at = c;
        if (wr_at < 0 && aw_cyc == exp_aw && w_cyc == exp_w && exp_aw > 0 &&
            (m_awready || m_wready || (aw_cyc > 0 && w_cyc > 0 && !m_awvalid && !m_wvalid)))
          if ((aw_d >= 0) && (w_d >= 0)) wr_at = c;
      end
      @(negedge clk);
    end
    chk("txn_bound", done, 1);
    // The cycle after DONE is idle: fault lasted exactly one cycle.
    #1;
    chk("idle_busy", axi_busy, 0);
    chk("idle_fault", axi_access_fault, 0);
    @(negedge clk);
  endtask

  initial begin
    rst = 1; axi_rd_en = 0; axi_wr_en = 0; axi_addr = '0; wr_data = '0; wr_strobe = '0;
    slave_idle();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", axi_busy, 0);
    chk("rst_valids", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);
    chk("rst_rd_data", axi_rd_data, 0);
    chk("rst_fault", axi_access_fault, 0);
    chk("prot", {m_awprot, m_arprot}, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);

    // Zero-wait read.
    txn(0, 1, 32'h10, 0, 0, 0, 0, 0, 0, 0, 32'hCAFE_0001, 2'd0);
    // Write with W accepted two cycles before AW.
    txn(1, 0, 32'h20, 32'h1234_5678, 4'b0011, 2, 0, 0, 0, 0, 0, 2'd0);
    // SLVERR read, then an OKAY read clears the fault.
    txn(0, 1, 32'h30, 0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 2'd2);
    txn(0, 1, 32'h34, 0, 0, 0, 0, 0, 1, 1, 32'h0000_0042, 2'd0);
    // Simultaneous read and write: write wins, no AR.
    txn(1, 1, 32'h40, 32'hA5A5_5A5A, 4'hF, 0, 1, 1, 0, 0, 0, 2'd1);
    // DECERR write.
    txn(1, 0, 32'h44, 32'h0BAD_F00D, 4'h8, 1, 1, 0, 0, 0, 0, 2'd3);
    // AR never accepted: timeout.
    txn(0, 1, 32'h50, 0, 0, 0, 0, 0, -1, 0, 32'h1111_1111, 2'd0);
    // R never returned: timeout, read data held.
    txn(0, 1, 32'h54, 0, 0, 0, 0, 0, 0, -1, 32'h2222_2222, 2'd0);
    // B never returned.
    txn(1, 0, 32'h58, 32'h3333_3333, 4'h1, 0, 0, -1, 0, 0, 0, 2'd0);

    // Randomized traffic.
    for (int i = 0; i < 24; i++) begin
      bit w;
      w = $urandom_range(0, 1);
      txn(w, w ? bit'($urandom_range(0, 1)) : 1'b1, $urandom, $urandom, 4'($urandom),
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 2'($urandom));
    end

    // Reset in the middle of a write.
    axi_wr_en = 1; axi_addr = 32'h60; wr_data = 32'h7777_7777; wr_strobe = 4'hF;
    @(negedge clk);
    #1;
    chk("mid_awvalid", m_awvalid, 1);
    chk("mid_wvalid", m_wvalid, 1);
    #1;
    rst = 1; axi_wr_en = 0;
    #1;
    chk("arst_valids", {m_awvalid, m_wvalid}, 0);
    chk("arst_busy", axi_busy, 0);
    exp_rd = '0;
    chk("arst_rd_data", axi_rd_data, exp_rd);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    txn(0, 1, 32'h64, 0, 0, 0, 0, 0, 0, 2, 32'h5EED_0001, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
